regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised multi-port register file for the pipelined MIPS core.
//   - NUM_RD asynchronous read ports, one synchronous write port.
//   - Register 0 hardwired to zero.
//   - Per-register pending-write scoreboard: the decode stage marks a destination
//     at issue; writeback clears the mark; hazard logic reads per-port pending flags.
// PARAMETERS
//   DATA_W   32  register width in bits
//   ADDR_W    5  register address width; depth = 2**ADDR_W
//   NUM_RD    2  number of read ports (1..4)
// PORTS
//   clock_in     in   1              system clock, rising edge
//   reset        in   1              asynchronous, active-low; clears registers and scoreboard
//   regWrite     in   1              writeback enable
//   writeReg     in   ADDR_W         writeback destination
//   writeData    in   DATA_W         writeback data
//   readReg      in   NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
//   readData     out  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
//   readPending  out  NUM_RD         1 = port i register has an outstanding write
//   issueValid   in   1              decode issues an instruction that writes issueReg
//   issueReg     in   ADDR_W         destination being issued
//   flush        in   1              pipeline flush; clears every pending bit
//   pendingCount out  ADDR_W+1       registered count of set pending bits
// BEHAVIOUR
//   Reset (reset=0, asynchronous): all regs=0, pending=0, pendingCount=0.
//     Hence readData=0 and readPending=0 until the first write.
//   Write: at posedge, if regWrite && writeReg!=0 then reg[writeReg]<=writeData.
//     Writes to register 0 are dropped.
//   Read: combinational, zero latency.
//     - readReg_i==0 -> readData_i=0 and readPending_i=0, always.
//     - Otherwise readData_i=reg[readReg_i] (bypass below when enabled).
//   Scoreboard, next-state per register r!=0 at posedge, priority high->low:
//     1. flush -> pending[r]<=0 (a same-cycle issue is discarded).
//     2. issueValid && issueReg==r -> pending[r]<=1.
//        Set wins over a same-cycle writeback to r: the new producer is outstanding.
//     3. regWrite && writeReg==r -> pending[r]<=0.
//     4. Otherwise hold.
//   pending[0] is constant 0. Issue to r0 and writeback to r0 have no effect.
//   pendingCount: registered and updated incrementally, +1/-1/0 per cycle.
//     - Must equal popcount(pending) every cycle. Flush sets it to 0.
//     - Issue to an already-pending reg with no clear: no change.
//     - Issue and writeback to the same reg: no change.
//     - Issue to r1 with writeback clearing pending r2: no change.
//     - Range 0..2**ADDR_W-1; no wrap is possible.
//   readPending_i = pending[readReg_i], subject to the bypass masking below.
//   Reset asserted mid-operation: everything clears immediately; no write completes.
// CONFIGURATION
//   REGFILE_WRITE_BYPASS_EN defined:
//     - When regWrite && writeReg==readReg_i && writeReg!=0:
//       readData_i=writeData (same-cycle write-through) and readPending_i=0.
//   REGFILE_WRITE_BYPASS_EN undefined:
//     - Reads return the pre-write value; the new value is visible the cycle after.
//     - readPending_i reflects the pending bit unmasked.
//   Default build: defined.
// TESTING
//   1. reset=0 for 3 cycles, then release -> readData(all ports)=0, readPending=0,
//      pendingCount=0.
//   2. Write r5=32'hDEADBEEF; next cycle read r5 on ports 0 and 1 -> both return
//      DEADBEEF. Write r0=32'h1234 -> r0 reads 0.
//   3. Bypass: regWrite r7=32'hA5A5A5A5 while readReg0=7.
//      - BYPASS_EN: readData0=A5A5A5A5 in that cycle.
//      - Without BYPASS_EN: old value 0 in that cycle, A5A5A5A5 the cycle after.
//   4. Scoreboard: issue r3, then issue r4 -> pendingCount=2, readPending high for r3.
//      Writeback r3 -> pendingCount=1. Issue r4 and writeback r4 in the same cycle
//      -> r4 stays pending, count=1.
//   5. Issue r8, r9, r10, then flush together with issueValid r11 -> all pending=0,
//      count=0, r11 not pending.
//   6. Random issue/writeback/flush for 10k cycles with async reset pulses mid-stream
//      -> pendingCount==popcount(pending) and reads match a reference model every cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a per-register pending-write scoreboard for the MIPS pipeline.
// Optional same-cycle write-through on reads is enabled by defining REGFILE_WRITE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clock_in,
    input  logic                     reset,
    input  logic                     regWrite,
    input  logic [ADDR_W-1:0]        writeReg,
    input  logic [DATA_W-1:0]        writeData,
    input  logic [NUM_RD*ADDR_W-1:0] readReg,
    output logic [NUM_RD*DATA_W-1:0] readData,
    output logic [NUM_RD-1:0]        readPending,
    input  logic                     issueValid,
    input  logic [ADDR_W-1:0]        issueReg,
    input  logic                     flush,
    output logic [ADDR_W:0]          pendingCount
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CountOne = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pendingQ, pendingD;
    logic [ADDR_W:0]   countQ, countD;
    logic              wrEn, issEn, incr, decr;

    // r0 never takes a write or a pending mark
    assign wrEn  = regWrite && (writeReg != '0);
    assign issEn = issueValid && (issueReg != '0);

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[writeReg] <= writeData;
        end
    end

    // Issue is applied after writeback so a new producer wins over a same-cycle clear
    always_comb begin
        pendingD = pendingQ;
        if (flush) begin
            pendingD = '0;
        end else begin
            if (wrEn) begin
                pendingD[writeReg] = 1'b0;
            end
            if (issEn) begin
                pendingD[issueReg] = 1'b1;
            end
        end
        pendingD[0] = 1'b0;
    end

    // Incremental popcount: a bit rises only if it was clear, falls only if not re-issued
    always_comb begin
        incr   = issEn && !pendingQ[issueReg];
        decr   = wrEn && pendingQ[writeReg] && !(issEn && (issueReg == writeReg));
        countD = countQ;
        if (flush) begin
            countD = '0;
        end else if (incr && !decr) begin
            countD = countQ + CountOne;
        end else if (decr && !incr) begin
            countD = countQ - CountOne;
        end
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            pendingQ <= '0;
            countQ   <= '0;
        end else begin
            pendingQ <= pendingD;
            countQ   <= countD;
        end
    end

    assign pendingCount = countQ;

    for (genvar p = 0; p < NUM_RD; p++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              pend;
        logic              hit;

        assign addr = readReg[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_WRITE_BYPASS_EN
        assign hit = wrEn && (writeReg == addr);
`else
        assign hit = 1'b0;
`endif

        always_comb begin
            data = '0;
            pend = 1'b0;
            if (addr == '0) begin
                data = '0;
                pend = 1'b0;
            end else if (hit) begin
                data = writeData;
                pend = 1'b0;
            end else begin
                data = regs[addr];
                pend = pendingQ[addr];
            end
        end

        assign readData[p*DATA_W +: DATA_W] = data;
        assign readPending[p]               = pend;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomised self-checking bench for regfile_scoreboard (DATA_W=32, ADDR_W=5,
// NUM_RD=2); expectations follow REGFILE_WRITE_BYPASS_EN when it is defined.
module tb_regfile_scoreboard;

    logic        clock_in;
    logic        reset;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [9:0]  readReg;
    logic [63:0] readData;
    logic [1:0]  readPending;
    logic        issueValid;
    logic [4:0]  issueReg;
    logic        flush;
    logic [5:0]  pendingCount;

    int nChecks = 0;
    int nFail   = 0;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    regfile_scoreboard #(
        .DATA_W(32),
        .ADDR_W(5),
        .NUM_RD(2)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .regWrite    (regWrite),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .readReg     (readReg),
        .readData    (readData),
        .readPending (readPending),
        .issueValid  (issueValid),
        .issueReg    (issueReg),
        .flush       (flush),
        .pendingCount(pendingCount)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        regWrite   = 1'b0;
        writeReg   = '0;
        writeData  = '0;
        issueValid = 1'b0;
        issueReg   = '0;
        flush      = 1'b0;
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset();
        idle();
        readReg = {5'd2, 5'd1};
        reset   = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        nChecks++;
        if (readData !== 64'h0) begin
            nFail++;
            $display("FAIL reset_data: got %h expected %h", readData, 64'h0);
        end
        nChecks++;
        if (readPending !== 2'b00) begin
            nFail++;
            $display("FAIL reset_pending: got %b expected 00", readPending);
        end
        nChecks++;
        if (pendingCount !== 6'd0) begin
            nFail++;
            $display("FAIL reset_count: got %0d expected 0", pendingCount);
        end
        tick();
    endtask

    task automatic test_write_read();
        regWrite  = 1'b1;
        writeReg  = 5'd5;
        writeData = 32'hDEADBEEF;
        readReg   = {5'd0, 5'd0};
        tick();
        idle();
        readReg = {5'd5, 5'd5};
        #1;
        nChecks++;
        if (readData !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            nFail++;
            $display("FAIL read_r5: got %h expected DEADBEEFDEADBEEF", readData);
        end
        regWrite  = 1'b1;
        writeReg  = 5'd0;
        writeData = 32'h1234;
        readReg   = {5'd0, 5'd0};
        #1;
        nChecks++;
        if (readData !== 64'h0) begin
            nFail++;
            $display("FAIL r0_same_cycle: got %h expected 0", readData);
        end
        tick();
        idle();
        #1;
        nChecks++;
        if (readData !== 64'h0) begin
            nFail++;
            $display("FAIL r0_after_write: got %h expected 0", readData);
        end
        tick();
    endtask

    task automatic test_bypass();
        logic [31:0] exp0;
        regWrite  = 1'b1;
        writeReg  = 5'd7;
        writeData = 32'hA5A5A5A5;
        readReg   = {5'd5, 5'd7};
        #1;
        exp0 = Bypass ? 32'hA5A5A5A5 : 32'h0;
        nChecks++;
        if (readData[31:0] !== exp0) begin
            nFail++;
            $display("FAIL bypass_same_cycle: got %h expected %h", readData[31:0], exp0);
        end
        nChecks++;
        if (readData[63:32] !== 32'hDEADBEEF) begin
            nFail++;
            $display("FAIL bypass_other_port: got %h expected DEADBEEF", readData[63:32]);
        end
        tick();
        idle();
        #1;
        nChecks++;
        if (readData[31:0] !== 32'hA5A5A5A5) begin
            nFail++;
            $display("FAIL bypass_next_cycle: got %h expected A5A5A5A5", readData[31:0]);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        issueValid = 1'b1;
        issueReg   = 5'd3;
        tick();
        issueReg = 5'd4;
        tick();
        idle();
        readReg = {5'd4, 5'd3};
        #1;
        nChecks++;
        if (pendingCount !== 6'd2) begin
            nFail++;
            $display("FAIL sb_count_two: got %0d expected 2", pendingCount);
        end
        nChecks++;
        if (readPending !== 2'b11) begin
            nFail++;
            $display("FAIL sb_pending_r3r4: got %b expected 11", readPending);
        end
        // Writeback r3 while port 0 reads r3
        regWrite  = 1'b1;
        writeReg  = 5'd3;
        writeData = 32'h33;
        #1;
        nChecks++;
        if (readPending[0] !== !Bypass) begin
            nFail++;
            $display("FAIL sb_wb_mask: got %b expected %b", readPending[0], !Bypass);
        end
        tick();
        idle();
        #1;
        nChecks++;
        if (pendingCount !== 6'd1 || readPending !== 2'b10) begin
            nFail++;
            $display("FAIL sb_after_wb: got count %0d pend %b expected 1 10",
                     pendingCount, readPending);
        end
        // Issue and writeback the same register: stays pending
        regWrite   = 1'b1;
        writeReg   = 5'd4;
        writeData  = 32'h44;
        issueValid = 1'b1;
        issueReg   = 5'd4;
        tick();
        idle();
        #1;
        nChecks++;
        if (pendingCount !== 6'd1 || readPending[1] !== 1'b1) begin
            nFail++;
            $display("FAIL sb_issue_wb_same: got count %0d pend %b expected 1 1",
                     pendingCount, readPending[1]);
        end
        // Re-issue an already-pending register
        issueValid = 1'b1;
        issueReg   = 5'd4;
        tick();
        idle();
        #1;
        nChecks++;
        if (pendingCount !== 6'd1) begin
            nFail++;
            $display("FAIL sb_reissue: got %0d expected 1", pendingCount);
        end
        // Issue r1 while writeback clears r4
        issueValid = 1'b1;
        issueReg   = 5'd1;
        regWrite   = 1'b1;
        writeReg   = 5'd4;
        writeData  = 32'h45;
        tick();
        idle();
        readReg = {5'd4, 5'd1};
        #1;
        nChecks++;
        if (pendingCount !== 6'd1 || readPending !== 2'b01) begin
            nFail++;
            $display("FAIL sb_swap: got count %0d pend %b expected 1 01",
                     pendingCount, readPending);
        end
        tick();
    endtask

    task automatic test_flush();
        issueValid = 1'b1;
        issueReg   = 5'd8;
        tick();
        issueReg = 5'd9;
        tick();
        issueReg = 5'd10;
        tick();
        idle();
        #1;
        nChecks++;
        if (pendingCount !== 6'd4) begin
            nFail++;
            $display("FAIL flush_pre_count: got %0d expected 4", pendingCount);
        end
        flush      = 1'b1;
        issueValid = 1'b1;
        issueReg   = 5'd11;
        tick();
        idle();
        readReg = {5'd11, 5'd8};
        #1;
        nChecks++;
        if (pendingCount !== 6'd0 || readPending !== 2'b00) begin
            nFail++;
            $display("FAIL flush_clear: got count %0d pend %b expected 0 00",
                     pendingCount, readPending);
        end
        issueValid = 1'b1;
        issueReg   = 5'd0;
        tick();
        idle();
        readReg = {5'd0, 5'd0};
        #1;
        nChecks++;
        if (pendingCount !== 6'd0 || readPending !== 2'b00) begin
            nFail++;
            $display("FAIL issue_r0: got count %0d pend %b expected 0 00",
                     pendingCount, readPending);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] mem [32];
        logic [31:0] pend;
        logic [4:0]  wr, rr;
        logic [31:0] expData;
        logic        expPend;
        int          expCount;

        // Resynchronise the model with a reset
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        pend = '0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 2000 == 999) begin
                // Async reset mid-cycle with a write and issue in flight
                wr         = 5'($urandom_range(1, 31));
                regWrite   = 1'b1;
                writeReg   = wr;
                writeData  = $urandom;
                issueValid = 1'b1;
                issueReg   = wr;
                #2;
                reset = 1'b0;
                #1;
                nChecks++;
                if (pendingCount !== 6'd0) begin
                    nFail++;
                    $display("FAIL rand_reset_count: cyc %0d got %0d expected 0",
                             cyc, pendingCount);
                end
                @(posedge clock_in);
                #1;
                idle();
                reset   = 1'b1;
                readReg = {wr, wr};
                #1;
                nChecks++;
                if (readData !== 64'h0 || readPending !== 2'b00) begin
                    nFail++;
                    $display("FAIL rand_reset_regs: cyc %0d got %h %b expected 0 00",
                             cyc, readData, readPending);
                end
                for (int i = 0; i < 32; i++) mem[i] = '0;
                pend = '0;
                @(posedge clock_in);
                #1;
                continue;
            end

            regWrite   = 1'($urandom_range(0, 1));
            writeReg   = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            writeData  = $urandom;
            issueValid = 1'($urandom_range(0, 1));
            issueReg   = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            flush      = ($urandom_range(0, 63) == 0);
            rr         = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
            readReg    = {5'($urandom_range(0, 31)), rr};
            #1;

            expCount = $countones(pend);
            nChecks++;
            if (pendingCount !== 6'(expCount)) begin
                nFail++;
                if (nFail < 20)
                    $display("FAIL rand_count: cyc %0d got %0d expected %0d",
                             cyc, pendingCount, expCount);
            end
            for (int p = 0; p < 2; p++) begin
                rr = readReg[p*5 +: 5];
                if (rr == 5'd0) begin
                    expData = '0;
                    expPend = 1'b0;
                end else if (Bypass && regWrite && writeReg == rr) begin
                    expData = writeData;
                    expPend = 1'b0;
                end else begin
                    expData = mem[rr];
                    expPend = pend[rr];
                end
                nChecks++;
                if (readData[p*32 +: 32] !== expData || readPending[p] !== expPend) begin
                    nFail++;
                    if (nFail < 20)
                        $display("FAIL rand_read: cyc %0d port %0d r%0d got %h/%b expected %h/%b",
                                 cyc, p, rr, readData[p*32 +: 32], readPending[p],
                                 expData, expPend);
                end
            end

            @(posedge clock_in);
            if (regWrite && writeReg != 5'd0) mem[writeReg] = writeData;
            if (flush) begin
                pend = '0;
            end else begin
                if (regWrite && writeReg != 5'd0) pend[writeReg] = 1'b0;
                if (issueValid && issueReg != 5'd0) pend[issueReg] = 1'b1;
            end
            #1;
        end
        idle();
    endtask

    initial begin
        idle();
        reset   = 1'b1;
        readReg = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
